// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types, constants and helper functions for the Wishbone arbiter/crossbar
package wb_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int WD_W    = 16;
   localparam int RR_MAX  = 8;
   localparam int ADR_MAX = 64;

   // Returns {found, index} of the first request strictly after 'last', searching upward with wrap over n masters.
   function automatic logic [3:0] rr_next(input logic [RR_MAX-1:0] req, input logic [2:0] last, input int n);
      logic [3:0] res;
      int         idx;
      res = '0;
      for (int k = RR_MAX; k >= 1; k--) begin
         if (k <= n) begin
            idx = (int'(last) + k) % n;
            if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
         end
      end
      return res;
   endfunction

   function automatic logic addr_match(input logic [ADR_MAX-1:0] adr, input logic [ADR_MAX-1:0] base,
                                       input logic [ADR_MAX-1:0] mask);
      return (adr & mask) == base;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin arbiter with registered one-hot grant and last-granted pointer
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NM = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NM-1:0] req,
   input  logic          load,
   input  logic          clear,
   output logic [NM-1:0] gnt
);

   logic [2:0]    ptr;
   logic [2:0]    gnt_idx;
   logic [3:0]    nxt;
   logic [NM-1:0] gnt_next;

   always_comb begin
      nxt      = rr_next(8'(req), ptr, NM);
      gnt_next = '0;
      gnt_idx  = '0;
      for (int i = 0; i < NM; i++) begin
         gnt_next[i] = nxt[3] && (nxt[2:0] == 3'(i));
         if (gnt[i]) gnt_idx = 3'(i);
      end
   end

   // Pointer resets to the top master so master 0 wins the first contest; it advances on release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt <= '0;
         ptr <= 3'(NM-1);
      end else if (load) begin
         gnt <= gnt_next;
      end else if (clear) begin
         gnt <= '0;
         ptr <= gnt_idx;
      end
   end

endmodule

// File: rtl/wb_arbiter_xbar.sv
// rtl/wb_arbiter_xbar.sv - shared-bus Wishbone interconnect, NM masters to NS slaves, one transfer in flight
// Optional bus watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_arbiter_xbar
   import wb_arb_pkg::*;
#(
   parameter int                NM      = 4,
   parameter int                NS      = 8,
   parameter int                AW      = 32,
   parameter int                DW      = 32,
   parameter logic [NS*AW-1:0]  S_BASE  = {NS{32'h0}},
   parameter logic [NS*AW-1:0]  S_MASK  = {NS{32'hF0000000}},
   parameter int                TIMEOUT = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NM*AW-1:0]     m_adr_i,
   input  logic [NM*DW-1:0]     m_dat_i,
   input  logic [NM*(DW/8)-1:0] m_sel_i,
   input  logic [NM-1:0]        m_we_i,
   input  logic [NM-1:0]        m_cyc_i,
   input  logic [NM-1:0]        m_stb_i,
   output logic [DW-1:0]        m_dat_o,
   output logic [NM-1:0]        m_ack_o,
   output logic [NM-1:0]        m_err_o,
   output logic [NM-1:0]        m_rty_o,
   output logic [AW-1:0]        s_adr_o,
   output logic [DW-1:0]        s_dat_o,
   output logic [DW/8-1:0]      s_sel_o,
   output logic                 s_we_o,
   output logic [NS-1:0]        s_cyc_o,
   output logic [NS-1:0]        s_stb_o,
   input  logic [NS*DW-1:0]     s_dat_i,
   input  logic [NS-1:0]        s_ack_i,
   input  logic [NS-1:0]        s_err_i,
   input  logic [NS-1:0]        s_rty_i,
   output logic [NM-1:0]        gnt_o
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("wb_arbiter_xbar: TIMEOUT out of range");
   end

   state_t          state, state_next;
   logic [NM-1:0]   gnt;
   logic            arb_load, arb_clear;
   logic            g_cyc, g_stb, g_we;
   logic [AW-1:0]   g_adr;
   logic [DW-1:0]   g_dat;
   logic [DW/8-1:0] g_sel;
   logic [NS-1:0]   dec_oh;
   logic            hit;
   logic [DW-1:0]   slv_dat;
   logic            slv_ack, slv_err, slv_rty;
   logic            int_err, wd_fire;

   wb_rr_arbiter #(.NM(NM)) u_arb (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .req   (m_cyc_i),
      .load  (arb_load),
      .clear (arb_clear),
      .gnt   (gnt)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      arb_load   = 1'b0;
      arb_clear  = 1'b0;
      case (state)
         IDLE: if (|m_cyc_i) begin
            state_next = BUSY;
            arb_load   = 1'b1;
         end
         BUSY: if (!g_cyc) begin
            state_next = IDLE;
            arb_clear  = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Grant is non-zero only while BUSY, so every shared signal idles at zero.
   always_comb begin
      g_cyc = 1'b0;
      g_stb = 1'b0;
      g_we  = 1'b0;
      g_adr = '0;
      g_dat = '0;
      g_sel = '0;
      for (int i = 0; i < NM; i++) begin
         if (gnt[i]) begin
            g_cyc = m_cyc_i[i];
            g_stb = m_cyc_i[i] & m_stb_i[i];
            g_we  = m_we_i[i];
            g_adr = m_adr_i[i*AW +: AW];
            g_dat = m_dat_i[i*DW +: DW];
            g_sel = m_sel_i[i*(DW/8) +: DW/8];
         end
      end
   end

   always_comb begin
      dec_oh = '0;
      hit    = 1'b0;
      for (int j = NS-1; j >= 0; j--) begin
         if (g_cyc && addr_match(ADR_MAX'(g_adr), ADR_MAX'(S_BASE[j*AW +: AW]), ADR_MAX'(S_MASK[j*AW +: AW]))) begin
            dec_oh    = '0;
            dec_oh[j] = 1'b1;
            hit       = 1'b1;
         end
      end
   end

   always_comb begin
      slv_dat = '0;
      for (int j = 0; j < NS; j++) begin
         if (dec_oh[j]) slv_dat = s_dat_i[j*DW +: DW];
      end
   end

   assign slv_ack = |(s_ack_i & dec_oh);
   assign slv_err = |(s_err_i & dec_oh);
   assign slv_rty = |(s_rty_i & dec_oh);

   // Unmapped responder: one err per strobe phase, a cycle after the strobe is seen.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) int_err <= 1'b0;
      else          int_err <= g_stb & ~hit & ~int_err;
   end

`ifdef WB_ARB_WATCHDOG_EN
   logic [WD_W-1:0] wd_cnt;
   logic            stalled;

   assign stalled = g_stb & ~(slv_ack | slv_err | slv_rty | int_err);
   assign wd_fire = g_stb & (wd_cnt == WD_W'(TIMEOUT));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)                wd_cnt <= '0;
      else if (wd_fire || !stalled) wd_cnt <= '0;
      else                         wd_cnt <= wd_cnt + WD_W'(1);
   end
`else
   assign wd_fire = 1'b0;
`endif

   assign s_adr_o = g_adr;
   assign s_dat_o = g_dat;
   assign s_sel_o = g_sel;
   assign s_we_o  = g_we;
   assign s_cyc_o = (g_cyc & ~wd_fire) ? dec_oh : '0;
   assign s_stb_o = (g_stb & ~wd_fire) ? dec_oh : '0;

   assign m_dat_o = slv_dat;
   assign m_ack_o = {NM{slv_ack}} & gnt;
   assign m_err_o = {NM{slv_err | int_err | wd_fire}} & gnt;
   assign m_rty_o = {NM{slv_rty}} & gnt;
   assign gnt_o   = gnt;

endmodule

// File: tb/tb_wb_arbiter_xbar.sv
// tb/tb_wb_arbiter_xbar.sv - scoreboard bench for wb_arbiter_xbar (watchdog case under WB_ARB_WATCHDOG_EN)
module tb_wb_arbiter_xbar;

   localparam int NM = 4;
   localparam int NS = 8;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef WB_ARB_WATCHDOG_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 255;
`endif
   localparam logic [NS*AW-1:0] BASES = {32'hB0000000, 32'hA0000000, 32'h90000000, 32'h80000000,
                                         32'h70000000, 32'h60000000, 32'h50000000, 32'h40000000};

   logic                 clk;
   logic                 rst_n;
   logic [NM*AW-1:0]     m_adr_i;
   logic [NM*DW-1:0]     m_dat_i;
   logic [NM*(DW/8)-1:0] m_sel_i;
   logic [NM-1:0]        m_we_i, m_cyc_i, m_stb_i;
   logic [DW-1:0]        m_dat_o;
   logic [NM-1:0]        m_ack_o, m_err_o, m_rty_o, gnt_o;
   logic [AW-1:0]        s_adr_o;
   logic [DW-1:0]        s_dat_o;
   logic [DW/8-1:0]      s_sel_o;
   logic                 s_we_o;
   logic [NS-1:0]        s_cyc_o, s_stb_o;
   logic [NS*DW-1:0]     s_dat_i;
   logic [NS-1:0]        s_ack_i, s_err_i, s_rty_i;

   wb_arbiter_xbar #(
      .NM(NM), .NS(NS), .AW(AW), .DW(DW),
      .S_BASE(BASES), .S_MASK({NS{32'hF0000000}}), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .m_err_o(m_err_o), .m_rty_o(m_rty_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .gnt_o(gnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: slave j returns adr ^ (0x11111111*(j+1)) and acks on the third strobe cycle.
   int  wcnt = 0;
   bit  stall = 1'b0;
   always_comb begin
      s_dat_i = '0;
      for (int j = 0; j < NS; j++) s_dat_i[j*DW +: DW] = s_adr_o ^ (32'h11111111 * 32'(j+1));
   end
   assign s_ack_i = (!stall && wcnt == 2) ? s_stb_o : '0;
   assign s_err_i = '0;
   assign s_rty_i = '0;
   always @(posedge clk) begin
      if (|s_stb_o && !(|s_ack_i)) wcnt <= wcnt + 1;
      else                         wcnt <= 0;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          m;
      bit          err;
      logic [31:0] dat;
   } exp_t;
   exp_t sb[$];

   task automatic push_exp(input int m, input logic [31:0] adr, input bit force_err);
      exp_t e;
      int   j;
      j     = int'(adr[31:28]) - 4;
      e.m   = m;
      e.err = force_err || j < 0 || j >= NS;
      e.dat = adr ^ (32'h11111111 * 32'(j+1));
      sb.push_back(e);
   endtask

   initial begin
      exp_t          e;
      logic [NM-1:0] oh;
      forever begin
         @(negedge clk);
         if (|(m_ack_o | m_err_o)) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_resp", {m_err_o, m_ack_o}, 64'h0);
            end else begin
               e  = sb.pop_front();
               oh = NM'(1) << e.m;
               check_eq("resp_vec", {m_err_o, m_ack_o}, e.err ? {oh, 4'b0} : {4'b0, oh});
               check_eq("resp_gnt", gnt_o, oh);
               if (!e.err) check_eq("resp_dat", m_dat_o, e.dat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_master(input int m, input bit cyc, input bit stb, input logic [31:0] adr);
      m_cyc_i[m]             = cyc;
      m_stb_i[m]             = stb;
      m_we_i[m]              = 1'b0;
      m_adr_i[m*AW +: AW]    = adr;
      m_sel_i[m*4 +: 4]      = 4'hF;
      m_dat_i[m*DW +: DW]    = 32'h0;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_gnt"}, gnt_o, 64'h0);
      check_eq({tag, "_scyc"}, s_cyc_o, 64'h0);
      check_eq({tag, "_sstb"}, s_stb_o, 64'h0);
      check_eq({tag, "_mresp"}, {m_ack_o, m_err_o, m_rty_o}, 64'h0);
      check_eq({tag, "_sbus"}, {s_we_o, s_sel_o, s_adr_o}, 64'h0);
      check_eq({tag, "_sdat"}, s_dat_o, 64'h0);
      check_eq({tag, "_mdat"}, m_dat_o, 64'h0);
   endtask

   // Per-master transfer engine: nleft strobes, gap idle cycles between strobes, start cycle offset.
   int          nleft[NM], gap[NM], gapc[NM], start_at[NM];
   bit          started[NM];
   logic [31:0] adr_cur[NM];
   int          stb_hits;

   task automatic cfg_clear();
      for (int m = 0; m < NM; m++) begin
         nleft[m] = 0; gap[m] = 0; gapc[m] = 0; start_at[m] = 0; started[m] = 1'b1; adr_cur[m] = '0;
      end
   endtask

   task automatic cfg(input int m, input logic [31:0] adr, input int n, input int g, input int st, input bit go);
      nleft[m] = n; gap[m] = g; gapc[m] = 0; start_at[m] = st; started[m] = go; adr_cur[m] = adr;
   endtask

   task automatic run_engine(input string tag, input int budget);
      int            cyc_n;
      bit            done;
      logic [NM-1:0] resp;
      cyc_n = 0;
      done  = 1'b0;
      do begin
         @(negedge clk);
         resp = m_ack_o | m_err_o;
         if (|s_stb_o) stb_hits++;
         tick();
         cyc_n++;
         for (int m = 0; m < NM; m++) begin
            if (!started[m]) begin
               if (cyc_n >= start_at[m] && nleft[m] > 0) begin
                  started[m] = 1'b1;
                  drive_master(m, 1'b1, 1'b1, adr_cur[m]);
               end
            end else if (m_stb_i[m] && resp[m]) begin
               nleft[m]--;
               adr_cur[m] += 32'd4;
               if (nleft[m] == 0)    drive_master(m, 1'b0, 1'b0, 32'h0);
               else if (gap[m] == 0) drive_master(m, 1'b1, 1'b1, adr_cur[m]);
               else begin
                  m_stb_i[m] = 1'b0;
                  gapc[m]    = gap[m] - 1;
               end
            end else if (m_cyc_i[m] && !m_stb_i[m]) begin
               if (gapc[m] == 0) drive_master(m, 1'b1, 1'b1, adr_cur[m]);
               else              gapc[m]--;
            end
         end
         done = 1'b1;
         for (int m = 0; m < NM; m++) if (!started[m] || nleft[m] != 0) done = 1'b0;
      end while (!done && cyc_n < budget);
      check_eq({tag, "_done"}, done, 64'h1);
      check_eq({tag, "_sb_empty"}, sb.size(), 64'h0);
   endtask

   initial begin
      rst_n   = 1'b0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      m_we_i  = '0; m_cyc_i = '0; m_stb_i = '0;
      cfg_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      tick();
      rst_n = 1'b1;

      // Single master read, slave 0, ack after two wait cycles.
      push_exp(0, 32'h40000010, 1'b0);
      tick();
      drive_master(0, 1'b1, 1'b1, 32'h40000010);
      cfg_clear();
      cfg(0, 32'h40000010, 1, 0, 0, 1'b1);
      @(negedge clk);
      check_eq("t1_stb_c0", s_stb_o, 64'h0);
      @(negedge clk);
      check_eq("t1_stb_c1", s_stb_o, 64'h01);
      check_eq("t1_gnt_c1", gnt_o, 64'h1);
      check_eq("t1_adr_c1", s_adr_o, 64'h40000010);
      run_engine("t1", 50);

      // Reset mid-transfer aborts the slave cycle; pointer returns to master 0.
      tick();
      drive_master(2, 1'b1, 1'b1, 32'h60000000);
      tick();
      @(negedge clk);
      check_eq("t6_stb", s_stb_o, 64'h04);
      check_eq("t6_gnt", gnt_o, 64'h4);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive_master(2, 1'b0, 1'b0, 32'h0);
      drive_master(0, 1'b1, 1'b1, 32'h40000020);
      drive_master(1, 1'b1, 1'b1, 32'h50000000);
      push_exp(0, 32'h40000020, 1'b0);
      push_exp(1, 32'h50000000, 1'b0);
      cfg_clear();
      cfg(0, 32'h40000020, 1, 0, 0, 1'b1);
      cfg(1, 32'h50000000, 1, 0, 0, 1'b1);
      @(negedge clk);
      check_idle("t6_after_rst");
      run_engine("t6", 60);

      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // Simultaneous requests from masters 0, 1, 3, then master 0 re-requests against master 1.
      cfg_clear();
      cfg(0, 32'h40000100, 1, 0, 1, 1'b0);
      cfg(1, 32'h70000000, 1, 0, 1, 1'b0);
      cfg(3, 32'hB0000000, 1, 0, 1, 1'b0);
      push_exp(0, 32'h40000100, 1'b0);
      push_exp(1, 32'h70000000, 1'b0);
      push_exp(3, 32'hB0000000, 1'b0);
      run_engine("t2", 80);
      cfg_clear();
      cfg(0, 32'h40000200, 1, 0, 1, 1'b0);
      cfg(1, 32'h50000010, 1, 0, 1, 1'b0);
      push_exp(0, 32'h40000200, 1'b0);
      push_exp(1, 32'h50000010, 1'b0);
      run_engine("t2b", 60);

      // Grant lock: master 1 bursts three strobes with 2-cycle gaps while master 2 waits.
      cfg_clear();
      cfg(1, 32'h50000000, 3, 2, 1, 1'b0);
      cfg(2, 32'h60000040, 1, 0, 2, 1'b0);
      push_exp(1, 32'h50000000, 1'b0);
      push_exp(1, 32'h50000004, 1'b0);
      push_exp(1, 32'h50000008, 1'b0);
      push_exp(2, 32'h60000040, 1'b0);
      run_engine("t3", 100);

      // Unmapped address: no slave strobe, one err per strobe.
      stb_hits = 0;
      cfg_clear();
      cfg(3, 32'hE0000000, 2, 1, 1, 1'b0);
      push_exp(3, 32'hE0000000, 1'b0);
      push_exp(3, 32'hE0000004, 1'b0);
      run_engine("t4", 60);
      check_eq("t4_no_stb", stb_hits, 64'h0);

`ifdef WB_ARB_WATCHDOG_EN
      // Stalled slave: watchdog err on the 9th stalled cycle with the strobe withdrawn.
      stall = 1'b1;
      push_exp(0, 32'h40000000, 1'b1);
      tick();
      drive_master(0, 1'b1, 1'b1, 32'h40000000);
      @(negedge clk);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k < 9) begin
            check_eq("t5_stb_stall", s_stb_o, 64'h01);
            check_eq("t5_no_err", m_err_o, 64'h0);
         end else begin
            check_eq("t5_stb_drop", s_stb_o, 64'h0);
            check_eq("t5_err", m_err_o, 64'h1);
         end
      end
      tick();
      drive_master(0, 1'b0, 1'b0, 32'h0);
      stall = 1'b0;
      repeat (3) tick();
      check_eq("t5_sb_empty", sb.size(), 64'h0);
`endif

      repeat (3) tick();
      check_eq("final_sb_empty", sb.size(), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_xbar.md
Name: wb_arbiter_xbar

Overview:
- Parametrised shared-bus Wishbone interconnect: NM masters, NS slaves, one transfer in flight at a time.
- Round-robin arbitration with the grant held for the whole of a master's cycle.
- Per-slave base/mask address decode, an internal error responder for unmapped addresses, and an optional bus watchdog.
- Sits between the lm32 instruction/data ports (plus future DMA masters) and the bram/uart/timer/flash slaves in the SoC top.

Parameters:
- NM, 4: number of masters (1..8).
- NS, 8: number of slaves (1..16).
- AW, 32: address width.
- DW, 32: data width; select width is DW/8.
- S_BASE, {NS{32'h0}}: flattened NS*AW base addresses; slave i uses bits [i*AW +: AW].
- S_MASK, {NS{32'hF0000000}}: flattened NS*AW decode masks.
- TIMEOUT, 255: watchdog limit in cycles (1..2^16-1).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- m_adr_i  in  NM*AW  master addresses
- m_dat_i  in  NM*DW  master write data
- m_sel_i  in  NM*DW/8  byte selects
- m_we_i  in  NM  write enables
- m_cyc_i  in  NM  cycle
- m_stb_i  in  NM  strobe
- m_dat_o  out  DW  read data, shared by all masters
- m_ack_o  out  NM  per-master ack
- m_err_o  out  NM  per-master err
- m_rty_o  out  NM  per-master rty
- s_adr_o  out  AW  shared slave address
- s_dat_o  out  DW  shared write data
- s_sel_o  out  DW/8  shared selects
- s_we_o  out  1  shared write enable
- s_cyc_o  out  NS  per-slave cycle
- s_stb_o  out  NS  per-slave strobe
- s_dat_i  in  NS*DW  slave read data
- s_ack_i  in  NS  slave ack
- s_err_i  in  NS  slave err
- s_rty_i  in  NS  slave rty
- gnt_o  out  NM  one-hot current grant, for debug LEDs

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_n_i is synchronous and active-low.
- Reset values:
  - gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o = 0.
  - s_we_o = 0; s_adr_o, s_dat_o, s_sel_o, m_dat_o = 0.
  - The round-robin pointer resets to master NM-1, so master 0 wins the first contest.
  - Watchdog counter = 0.
- FSM IDLE:
  - If any m_cyc_i is set, register a one-hot grant to the first requesting master after the last-granted index, searching upward with wrap.
  - Go to BUSY. Arbitration latency is 1 cycle: a master's cyc at edge N produces slave stb visible after edge N+1.
- FSM BUSY:
  - Slave-side shared signals mux from the granted master.
  - Only the decoded slave sees s_cyc_o/s_stb_o = m_cyc_i & m_stb_i of the granted master.
  - Responses from the decoded slave pass combinationally to the granted master only; all other masters see 0.
  - When the granted master's m_cyc_i drops: go to IDLE, update the pointer, clear gnt_o. Re-arbitration happens no earlier than the next cycle.
- Grant lock: a grant is never revoked while the granted master's cyc is high, including across bursts and strobe gaps.
- Decode:
  - Combinational. Slave i matches when (adr & S_MASK_i) == S_BASE_i.
  - If several slaves match, the lowest index wins.
- Unmapped address (no match):
  - No s_stb_o is asserted.
  - The internal responder asserts m_err_o for exactly 1 cycle, one cycle after stb is seen; one err per strobe phase.
- Simultaneous requests: only the master selected by round-robin is granted; the others wait with cyc held.
- Reset mid-transfer: all outputs return to reset values at the next edge. The slave cycle is aborted without an ack.
- Error and retry pass through unchanged from the slave.

Optional Feature:
- Macro: WB_ARB_WATCHDOG_EN.
- When defined:
  - A 16-bit counter increments each BUSY cycle in which the granted stb is high and no ack/err/rty is returned. It clears otherwise.
  - When the counter equals TIMEOUT: force m_err_o high for 1 cycle, deassert s_stb_o and s_cyc_o for that cycle, and clear the counter.
- When undefined: no counter logic; a stalled slave holds the bus forever.

Decomposition:
- Package wb_arb_pkg:
  - FSM state encoding (IDLE, BUSY).
  - Width helper constant for the counter.
  - Function for round-robin next-grant on an NM-bit request vector.
  - Function for address match.
- Sub-module wb_rr_arbiter: request vector, pointer and registered one-hot grant, instantiated once.

Test Plan:
- Single master 0 reads 0x40000010 with slave 0 at base 0x40000000, mask 0xF0000000, slave ack after 2 cycles:
  - s_stb_o[0] rises 1 cycle after m_stb_i[0].
  - m_dat_o equals the slave data in the ack cycle; gnt_o = 4'b0001.
- Masters 0, 1 and 3 all assert cyc in the same cycle and each performs 1 transfer: grants are issued in order 0, 1, 3, then 0 again after 0 re-requests.
- Master 1 holds cyc over 3 strobes with a 2-cycle stb gap while master 2 requests: gnt_o stays 4'b0010 until m_cyc_i[1] falls, then becomes 4'b0100.
- Access to unmapped 0xE0000000: no s_stb_o asserted; m_err_o pulses 1 cycle; a second strobe yields a second err.
- With WB_ARB_WATCHDOG_EN and TIMEOUT = 8, slave never acks: m_err_o asserts on the 9th stalled cycle and s_stb_o drops for that cycle.
- rst_n_i low for 1 cycle mid-transfer: next cycle all outputs are 0, and a new request is granted to master 0.
